// File: rtl/stop_watch_ctrl.sv
// Stopwatch run-control: debounces start/stop and lap/reset buttons plus the direction switch,
// sequences IDLE/RUN/LAP/PAUSE, and drives the BCD counter's enable, direction and clear.
module stop_watch_ctrl #(
  parameter int unsigned DB_COUNT = 1_000_000,
  parameter int unsigned DB_WIDTH = 20
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        btn_ss,
  input  logic        btn_lr,
  input  logic        sw_up,
  input  logic [15:0] cnt_digits,
  output logic        count_en,
  output logic        count_up,
  output logic        count_clr,
  output logic [15:0] disp_digits,
  output logic        lap_active,
  output logic        done
);

  localparam int unsigned NumIn = 3;
  localparam logic [DB_WIDTH-1:0] DbMax = DB_WIDTH'(DB_COUNT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    LAP   = 2'd2,
    PAUSE = 2'd3
  } state_e;

  // Input channels: bit 0 = start/stop, bit 1 = lap/reset, bit 2 = direction switch
  logic [NumIn-1:0]    raw_c;
  logic [NumIn-1:0]    sync1_q, sync2_q;
  logic [NumIn-1:0]    level_q, level_d;
  logic [NumIn-1:0]    flip_c;
  logic [DB_WIDTH-1:0] cnt_q [NumIn];
  logic [DB_WIDTH-1:0] cnt_d [NumIn];
  logic [1:0]          vld_q, vld_d;
  logic [1:0]          armed_q, armed_d;
  logic [1:0]          press_q, press_d;

  state_e      state_q, state_d;
  logic        count_en_q, count_en_d;
  logic        count_up_q, count_up_d;
  logic        count_clr_q, count_clr_d;
  logic        lap_active_q, lap_active_d;
  logic        done_q, done_d;
  logic [15:0] snap_q, snap_d;

  logic ss_p, lr_p, down_zero_c;

  assign raw_c = {sw_up, btn_lr, btn_ss};

  // Stability counters; a button only arms once it has been seen released after reset
  always_comb begin
    flip_c  = '0;
    vld_d   = {vld_q[0], 1'b1};
    for (int unsigned i = 0; i < NumIn; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (cnt_q[i] == DbMax) flip_c[i] = 1'b1;
        else                   cnt_d[i] = cnt_q[i] + DB_WIDTH'(1);
      end
    end
    level_d = level_q ^ flip_c;
    press_d = flip_c[1:0] & ~level_q[1:0] & armed_q;
    armed_d = armed_q | ({2{vld_q[1]}} & ~sync2_q[1:0] & ~level_q[1:0]);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      vld_q   <= '0;
      armed_q <= '0;
      press_q <= '0;
      for (int unsigned i = 0; i < NumIn; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= raw_c;
      sync2_q <= sync1_q;
      level_q <= level_d;
      vld_q   <= vld_d;
      armed_q <= armed_d;
      press_q <= press_d;
      for (int unsigned i = 0; i < NumIn; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign ss_p        = press_q[0];
  assign lr_p        = press_q[1];
  assign down_zero_c = ~count_up_q & (cnt_digits == 16'h0000);

  // Next state; a down-count reaching zero overrides any button press
  always_comb begin
    state_d     = state_q;
    count_up_d  = count_up_q;
    count_clr_d = 1'b0;
    done_d      = 1'b0;
    snap_d      = snap_q;
    case (state_q)
      IDLE: begin
        count_up_d = level_q[2];
        if (ss_p) begin
          if (!down_zero_c) state_d = RUN;
        end else if (lr_p) begin
          count_clr_d = 1'b1;
        end
      end
      RUN: begin
        if (down_zero_c) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (ss_p) begin
          state_d = PAUSE;
        end else if (lr_p) begin
          state_d = LAP;
          snap_d  = cnt_digits;
        end
      end
      LAP: begin
        if (down_zero_c) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (ss_p) begin
          state_d = PAUSE;
        end else if (lr_p) begin
          state_d = RUN;
        end
      end
      PAUSE: begin
        count_up_d = level_q[2];
        if (ss_p) begin
          state_d = RUN;
        end else if (lr_p) begin
          state_d     = IDLE;
          count_clr_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    count_en_d   = (state_d == RUN) || (state_d == LAP);
    lap_active_d = (state_d == LAP);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q      <= IDLE;
      count_en_q   <= 1'b0;
      count_up_q   <= 1'b1;
      count_clr_q  <= 1'b0;
      lap_active_q <= 1'b0;
      done_q       <= 1'b0;
      snap_q       <= '0;
    end else begin
      state_q      <= state_d;
      count_en_q   <= count_en_d;
      count_up_q   <= count_up_d;
      count_clr_q  <= count_clr_d;
      lap_active_q <= lap_active_d;
      done_q       <= done_d;
      snap_q       <= snap_d;
    end
  end

  assign count_en    = count_en_q;
  assign count_up    = count_up_q;
  assign count_clr   = count_clr_q;
  assign lap_active  = lap_active_q;
  assign done        = done_q;
  assign disp_digits = lap_active_q ? snap_q : cnt_digits;

endmodule

// File: tb/tb_stop_watch_ctrl.sv
// Directed bench for stop_watch_ctrl with DB_COUNT=4 (button-to-output latency of 7 cycles).
module tb_stop_watch_ctrl;

  localparam int unsigned DbCount = 4;
  localparam int unsigned DbWidth = 3;

  logic        clk = 1'b0;
  logic        clr;
  logic        btn_ss, btn_lr, sw_up;
  logic [15:0] cnt_digits;
  logic        count_en, count_up, count_clr, lap_active, done;
  logic [15:0] disp_digits;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        ss;
    logic        lr;
    logic        sw;
    logic [15:0] cnt;
    int          cyc;
    logic        en;
    logic        up;
    logic        cl;
    logic        lap;
    logic        dn;
    logic [15:0] disp;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  stop_watch_ctrl #(.DB_COUNT(DbCount), .DB_WIDTH(DbWidth)) dut (
    .clk        (clk),
    .clr        (clr),
    .btn_ss     (btn_ss),
    .btn_lr     (btn_lr),
    .sw_up      (sw_up),
    .cnt_digits (cnt_digits),
    .count_en   (count_en),
    .count_up   (count_up),
    .count_clr  (count_clr),
    .disp_digits(disp_digits),
    .lap_active (lap_active),
    .done       (done)
  );

  task automatic chk(input string nm, input int row, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
    end
  endtask

  task automatic check_outs(input int row, input logic en, input logic up, input logic cl,
                            input logic lap, input logic dn, input logic [15:0] disp);
    chk("count_en",    row, 16'(count_en),   16'(en));
    chk("count_up",    row, 16'(count_up),   16'(up));
    chk("count_clr",   row, 16'(count_clr),  16'(cl));
    chk("lap_active",  row, 16'(lap_active), 16'(lap));
    chk("done",        row, 16'(done),       16'(dn));
    chk("disp_digits", row, disp_digits,     disp);
  endtask

  task automatic add(input logic ss, input logic lr, input logic sw, input logic [15:0] cnt,
                     input int cyc, input logic en, input logic up, input logic cl,
                     input logic lap, input logic dn, input logic [15:0] disp);
    vec_t v;
    v.ss = ss; v.lr = lr; v.sw = sw; v.cnt = cnt; v.cyc = cyc;
    v.en = en; v.up = up; v.cl = cl; v.lap = lap; v.dn = dn; v.disp = disp;
    vecs.push_back(v);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // Each row: drive inputs, advance cyc clocks, then check outputs.
    //   ss lr sw  cnt       cyc en up cl lap dn disp
    // start/stop, pause, lap/reset clear
    add(0, 0, 1, 16'h0010, 12, 0, 1, 0, 0, 0, 16'h0010);
    add(1, 0, 1, 16'h0010,  6, 0, 1, 0, 0, 0, 16'h0010);
    add(1, 0, 1, 16'h0010,  1, 1, 1, 0, 0, 0, 16'h0010);
    add(1, 0, 1, 16'h0010,  3, 1, 1, 0, 0, 0, 16'h0010);
    add(0, 0, 1, 16'h0010, 10, 1, 1, 0, 0, 0, 16'h0010);
    add(1, 0, 1, 16'h0010,  7, 0, 1, 0, 0, 0, 16'h0010);
    add(0, 0, 1, 16'h0010, 10, 0, 1, 0, 0, 0, 16'h0010);
    add(0, 1, 1, 16'h0010,  6, 0, 1, 0, 0, 0, 16'h0010);
    add(0, 1, 1, 16'h0010,  1, 0, 1, 1, 0, 0, 16'h0010);
    add(0, 1, 1, 16'h0010,  1, 0, 1, 0, 0, 0, 16'h0010);
    add(0, 0, 1, 16'h0010, 10, 0, 1, 0, 0, 0, 16'h0010);
    // bounce: glitches of 1, 2 and 3 cycles
    add(1, 0, 1, 16'h0010,  1, 0, 1, 0, 0, 0, 16'h0010);
    add(0, 0, 1, 16'h0010,  1, 0, 1, 0, 0, 0, 16'h0010);
    add(1, 0, 1, 16'h0010,  2, 0, 1, 0, 0, 0, 16'h0010);
    add(0, 0, 1, 16'h0010,  1, 0, 1, 0, 0, 0, 16'h0010);
    add(1, 0, 1, 16'h0010,  3, 0, 1, 0, 0, 0, 16'h0010);
    add(0, 0, 1, 16'h0010, 12, 0, 1, 0, 0, 0, 16'h0010);
    // lap freeze and release
    add(1, 0, 1, 16'h0123,  7, 1, 1, 0, 0, 0, 16'h0123);
    add(0, 0, 1, 16'h0123, 10, 1, 1, 0, 0, 0, 16'h0123);
    add(0, 1, 1, 16'h0123,  7, 1, 1, 0, 1, 0, 16'h0123);
    add(0, 1, 1, 16'h0124,  1, 1, 1, 0, 1, 0, 16'h0123);
    add(0, 0, 1, 16'h0125, 10, 1, 1, 0, 1, 0, 16'h0123);
    add(0, 1, 1, 16'h0130,  7, 1, 1, 0, 0, 0, 16'h0130);
    add(0, 0, 1, 16'h0131, 10, 1, 1, 0, 0, 0, 16'h0131);
    // direction held in RUN, simultaneous presses, clear from PAUSE
    add(0, 0, 0, 16'h0131, 12, 1, 1, 0, 0, 0, 16'h0131);
    add(1, 1, 0, 16'h0131,  7, 0, 1, 0, 0, 0, 16'h0131);
    add(1, 1, 0, 16'h0131,  1, 0, 0, 0, 0, 0, 16'h0131);
    add(0, 0, 0, 16'h0131, 10, 0, 0, 0, 0, 0, 16'h0131);
    add(0, 1, 0, 16'h0131,  7, 0, 0, 1, 0, 0, 16'h0131);
    add(0, 1, 0, 16'h0131,  1, 0, 0, 0, 0, 0, 16'h0131);
    add(0, 0, 0, 16'h0000, 10, 0, 0, 0, 0, 0, 16'h0000);
    // down-count: start refused at zero, then run to zero
    add(1, 0, 0, 16'h0000,  7, 0, 0, 0, 0, 0, 16'h0000);
    add(1, 0, 0, 16'h0000,  1, 0, 0, 0, 0, 0, 16'h0000);
    add(0, 0, 0, 16'h0000, 10, 0, 0, 0, 0, 0, 16'h0000);
    add(1, 0, 0, 16'h0002,  7, 1, 0, 0, 0, 0, 16'h0002);
    add(0, 0, 0, 16'h0001, 10, 1, 0, 0, 0, 0, 16'h0001);
    add(0, 0, 0, 16'h0000,  1, 0, 0, 0, 0, 1, 16'h0000);
    add(0, 0, 0, 16'h0000,  1, 0, 0, 0, 0, 0, 16'h0000);
    add(1, 0, 0, 16'h0000,  7, 0, 0, 0, 0, 0, 16'h0000);
    add(0, 0, 0, 16'h0000, 10, 0, 0, 0, 0, 0, 16'h0000);
    // back into LAP ahead of the mid-operation reset
    add(0, 0, 1, 16'h0500, 12, 0, 1, 0, 0, 0, 16'h0500);
    add(1, 0, 1, 16'h0500,  7, 1, 1, 0, 0, 0, 16'h0500);
    add(0, 0, 1, 16'h0500, 10, 1, 1, 0, 0, 0, 16'h0500);
    add(0, 1, 1, 16'h0500,  7, 1, 1, 0, 1, 0, 16'h0500);
    add(0, 0, 1, 16'h0501, 10, 1, 1, 0, 1, 0, 16'h0500);

    clr        = 1'b1;
    btn_ss     = 1'b0;
    btn_lr     = 1'b0;
    sw_up      = 1'b1;
    cnt_digits = 16'h0010;
    wait_cycles(2);
    check_outs(-1, 0, 1, 0, 0, 0, 16'h0010);
    clr = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      btn_ss     = vecs[i].ss;
      btn_lr     = vecs[i].lr;
      sw_up      = vecs[i].sw;
      cnt_digits = vecs[i].cnt;
      wait_cycles(vecs[i].cyc);
      check_outs(i, vecs[i].en, vecs[i].up, vecs[i].cl, vecs[i].lap, vecs[i].dn, vecs[i].disp);
    end

    // Reset while in LAP with start/stop held through the reset release
    clr        = 1'b1;
    btn_ss     = 1'b1;
    cnt_digits = 16'h0502;
    wait_cycles(1);
    check_outs(100, 0, 1, 0, 0, 0, 16'h0502);
    wait_cycles(2);
    clr = 1'b0;
    wait_cycles(20);
    check_outs(101, 0, 1, 0, 0, 0, 16'h0502);
    btn_ss = 1'b0;
    wait_cycles(10);
    check_outs(102, 0, 1, 0, 0, 0, 16'h0502);
    btn_ss = 1'b1;
    wait_cycles(6);
    check_outs(103, 0, 1, 0, 0, 0, 16'h0502);
    wait_cycles(1);
    check_outs(104, 1, 1, 0, 0, 0, 16'h0502);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
